// File: rtl/ip_packet_rx_if.sv
// Byte-wide MAC receive stream plus the result handshake towards the accelerator.
// master = MAC/accelerator environment, slave = the packet receiver.
interface ip_packet_rx_if;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_TUSER;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [9:0]  SENDER_MESSAGE;
    logic        MESSAGE_VALID;
    logic        MESSAGE_READY;

    modport master (
        output MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_LAST, MAC_DATA_TUSER, MESSAGE_READY,
        input  MAC_DATA_READY, SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, SENDER_MESSAGE, MESSAGE_VALID
    );

    modport slave (
        input  MAC_DATA_IN, MAC_DATA_VALID, MAC_DATA_LAST, MAC_DATA_TUSER, MESSAGE_READY,
        output MAC_DATA_READY, SENDER_IP_ADDRESS, SENDER_MAC_ADDRESS, SENDER_MESSAGE, MESSAGE_VALID
    );
endinterface

// File: rtl/ip_packet_rx.sv
// IPv4 frame receiver: parses Ethernet/IPv4 headers LSB-first, filters the frame and
// hands the sender addresses and 10-bit message to the accelerator.
module ip_packet_rx #(
    parameter int ETH_HDR_BYTES  = 14,
    parameter int IP_HDR_BYTES   = 20,
    parameter int DATA_BYTES     = 26,
    parameter bit CHECK_CHECKSUM = 1'b1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [31:0]          ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]          ACCELERATOR_MAC_ADDRESS,
    ip_packet_rx_if.slave        rx,
    output logic [15:0]          DROP_COUNT
);
    typedef enum logic [2:0] {ETH_HDR, IP_HDR, USER_DATA, DRAIN, HOLD} state_t;

    localparam logic [7:0] ETH_END  = 8'(ETH_HDR_BYTES - 1);
    localparam logic [7:0] IP_END   = 8'(IP_HDR_BYTES - 1);
    localparam logic [7:0] DATA_END = 8'(DATA_BYTES - 1);

    state_t      state, state_nxt;
    logic [7:0]  byte_cnt;
    logic        beat, frame_end, cnt_clr;
    logic        drop_flag, drop_prev, byte_bad, frame_bad, drop_inc;
    logic        mac_local_ok, mac_bcast_ok, mac_local_prev, mac_bcast_prev;
    logic        mac_byte_local, ip_byte_match;
    logic [7:0]  csum_lo;
    logic [15:0] csum, csum_fold;
    logic [16:0] csum_acc;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [9:0]  message;

    assign rx.MAC_DATA_READY = (state != HOLD);
    assign rx.MESSAGE_VALID  = (state == HOLD);
    assign beat      = rx.MAC_DATA_VALID && rx.MAC_DATA_READY;
    assign frame_end = beat && rx.MAC_DATA_LAST;
    assign cnt_clr   = (state_nxt != state) || frame_end;

    // Sticky flags restart on the first byte of each frame.
    assign drop_prev      = (state == ETH_HDR && byte_cnt == '0) ? 1'b0 : drop_flag;
    assign frame_bad      = drop_prev | byte_bad;
    assign mac_local_prev = (byte_cnt == '0) ? 1'b1 : mac_local_ok;
    assign mac_bcast_prev = (byte_cnt == '0) ? 1'b1 : mac_bcast_ok;

    // Ones-complement add of {odd, even} with end-around carry folded per word.
    assign csum_acc  = {1'b0, csum} + {1'b0, rx.MAC_DATA_IN, csum_lo};
    assign csum_fold = csum_acc[15:0] + {15'd0, csum_acc[16]};

    always_comb begin
        mac_byte_local = 1'b0;
        ip_byte_match  = 1'b0;
        for (int unsigned i = 0; i < 6; i++)
            if (byte_cnt == 8'(i))
                mac_byte_local = (rx.MAC_DATA_IN == ACCELERATOR_MAC_ADDRESS[8*i +: 8]);
        for (int unsigned i = 0; i < 4; i++)
            if (byte_cnt == 8'(16 + i))
                ip_byte_match = (rx.MAC_DATA_IN == ACCELERATOR_IP_ADDRESS[8*i +: 8]);
    end

    always_comb begin
        state_nxt = state;
        byte_bad  = 1'b0;
        drop_inc  = 1'b0;
        unique case (state)
            ETH_HDR: begin
                if (byte_cnt == 8'd5 && !((mac_local_prev && mac_byte_local) ||
                                          (mac_bcast_prev && rx.MAC_DATA_IN == 8'hFF)))
                    byte_bad = 1'b1;
                if (byte_cnt == 8'd12 && rx.MAC_DATA_IN != 8'h00) byte_bad = 1'b1;
                if (byte_cnt == 8'd13 && rx.MAC_DATA_IN != 8'h08) byte_bad = 1'b1;
                if (beat) begin
                    if (rx.MAC_DATA_LAST)        drop_inc  = 1'b1;
                    else if (byte_cnt == ETH_END) state_nxt = IP_HDR;
                end
            end
            IP_HDR: begin
                if (byte_cnt == 8'd0 && rx.MAC_DATA_IN != 8'h45) byte_bad = 1'b1;
                if (byte_cnt >= 8'd16 && byte_cnt <= 8'd19 && !ip_byte_match) byte_bad = 1'b1;
                if (beat) begin
                    if (rx.MAC_DATA_LAST) begin
                        state_nxt = ETH_HDR;
                        drop_inc  = 1'b1;
                    end else if (byte_cnt == IP_END) begin
                        state_nxt = USER_DATA;
                    end
                end
            end
            USER_DATA: begin
                if (beat) begin
                    if (byte_cnt == DATA_END) begin
                        if (!rx.MAC_DATA_LAST) begin
                            state_nxt = DRAIN;
                        end else if (!frame_bad && !rx.MAC_DATA_TUSER &&
                                     (!CHECK_CHECKSUM || csum == 16'hFFFF)) begin
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = ETH_HDR;
                            drop_inc  = 1'b1;
                        end
                    end else if (rx.MAC_DATA_LAST) begin
                        state_nxt = ETH_HDR;
                        drop_inc  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (frame_end) begin
                    state_nxt = ETH_HDR;
                    drop_inc  = 1'b1;
                end
            end
            HOLD: begin
                if (rx.MESSAGE_READY) state_nxt = ETH_HDR;
            end
            default: state_nxt = ETH_HDR;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state                 <= ETH_HDR;
            byte_cnt              <= '0;
            drop_flag             <= 1'b0;
            mac_local_ok          <= 1'b0;
            mac_bcast_ok          <= 1'b0;
            csum                  <= '0;
            csum_lo               <= '0;
            src_mac               <= '0;
            src_ip                <= '0;
            message               <= '0;
            DROP_COUNT            <= '0;
            rx.SENDER_IP_ADDRESS  <= '0;
            rx.SENDER_MAC_ADDRESS <= '0;
            rx.SENDER_MESSAGE     <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)   byte_cnt <= '0;
            else if (beat) byte_cnt <= byte_cnt + 8'd1;
            if (drop_inc && DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 16'd1;

            if (beat) begin
                drop_flag <= frame_bad;
                if (state == ETH_HDR) begin
                    mac_local_ok <= mac_local_prev && mac_byte_local;
                    mac_bcast_ok <= mac_bcast_prev && (rx.MAC_DATA_IN == 8'hFF);
                    for (int unsigned i = 0; i < 6; i++)
                        if (byte_cnt == 8'(6 + i)) src_mac[8*i +: 8] <= rx.MAC_DATA_IN;
                end
                if (state == IP_HDR) begin
                    if (!byte_cnt[0]) begin
                        csum_lo <= rx.MAC_DATA_IN;
                        if (byte_cnt == '0) csum <= '0;
                    end else begin
                        csum <= csum_fold;
                    end
                    for (int unsigned i = 0; i < 4; i++)
                        if (byte_cnt == 8'(12 + i)) src_ip[8*i +: 8] <= rx.MAC_DATA_IN;
                end
                if (state == USER_DATA) begin
                    if (byte_cnt == 8'd0) message[7:0] <= rx.MAC_DATA_IN;
                    if (byte_cnt == 8'd1) message[9:8] <= rx.MAC_DATA_IN[1:0];
                end
            end

            if (state != HOLD && state_nxt == HOLD) begin
                rx.SENDER_IP_ADDRESS  <= src_ip;
                rx.SENDER_MAC_ADDRESS <= src_mac;
                rx.SENDER_MESSAGE     <= message;
            end
        end
    end
endmodule

// File: doc/ip_packet_rx.md
# ip_packet_rx

Receive-side counterpart of the accelerator's IPv4 transmitter. It consumes the byte-wide AXI-Stream from the MAC and parses the 14-byte Ethernet header, the 20-byte IPv4 header and the 26-byte user payload. It filters frames by destination MAC address, EtherType, IP version, header checksum and destination IP address. For each accepted frame it hands the sender's addresses and the 10-bit message to the accelerator over a valid/ready handshake.

## Interface
- `ETH_HDR_BYTES`, 14: Ethernet header length.
- `IP_HDR_BYTES`, 20: IPv4 header length.
- `DATA_BYTES`, 26: user payload length; the frame is 60 bytes, with the FCS already stripped by the MAC.
- `CHECK_CHECKSUM`, 1: when 1, frames with a bad IPv4 header checksum are dropped.

- `ACLK` in 1: the only clock.
- `ARESET` in 1: asynchronous, active-high reset.
- `ACCELERATOR_IP_ADDRESS` in 32: local IP address, static.
- `ACCELERATOR_MAC_ADDRESS` in 48: local MAC address, static.
- `MAC_DATA_IN` in 8: stream byte.
- `MAC_DATA_VALID` in 1: stream valid.
- `MAC_DATA_READY` out 1: stream ready.
- `MAC_DATA_LAST` in 1: last byte of the frame.
- `MAC_DATA_TUSER` in 1: MAC error flag; only meaningful on the LAST beat.
- `SENDER_IP_ADDRESS` out 32: IP source address of the held frame.
- `SENDER_MAC_ADDRESS` out 48: MAC source address of the held frame.
- `SENDER_MESSAGE` out 10: payload bits.
- `MESSAGE_VALID` out 1: result available.
- `MESSAGE_READY` in 1: accelerator accepts the result.
- `DROP_COUNT` out 16: count of dropped frames; saturates at 0xFFFF.

## Operation
- **Beat acceptance.** A beat is accepted when `MAC_DATA_VALID && MAC_DATA_READY`. The byte counter (8-bit) advances only on accepted beats and resets to 0 on every state change.
- **Byte order.** Every multi-byte field arrives least-significant byte first.
  - Byte k of a 48-bit address fills bits [8k+7:8k].
  - EtherType arrives as 0x00 then 0x08.
  - IP length arrives as 0x2E then 0x00.
- **ETH_HDR state** (initial state after reset; `MAC_DATA_READY` = 1).
  - Bytes 0–5 form the destination MAC. It must equal `ACCELERATOR_MAC_ADDRESS` or be all-ones (broadcast).
  - Bytes 6–11 are latched as the source MAC.
  - Bytes 12–13 must be 0x00, 0x08.
  - On byte 13, go to IP_HDR.
- **IP_HDR state.**
  - Byte 0 must be 0x45.
  - Bytes 12–15 are latched as the source IP.
  - Bytes 16–19 form the destination IP and must equal `ACCELERATOR_IP_ADDRESS`.
  - Bytes 1–11 are not field-checked, but they do enter the checksum.
  - On byte 19, go to USER_DATA.
- **Checksum.**
  - Form each 16-bit word as {odd byte, even byte}.
  - Keep a 17-bit accumulator and fold the end-around carry after every word.
  - The header passes when the folded sum over all 10 words is 0xFFFF.
- **USER_DATA state.**
  - Byte 0 fills `message[7:0]`.
  - Byte 1 bits [1:0] fill `message[9:8]`; its upper bits are ignored.
  - Bytes 2 to `DATA_BYTES`-1 are ignored.
  - On byte `DATA_BYTES`-1 with LAST=1:
    - if no check failed, `TUSER`=0 and (when `CHECK_CHECKSUM`=1) the checksum passed, go to HOLD;
    - otherwise go to ETH_HDR and increment `DROP_COUNT`.
- **Drop flag.** Any field mismatch sets a sticky drop flag. The frame is still consumed to its end; the flag clears when the next frame starts.
- **Runt frame.** LAST arrives before payload byte `DATA_BYTES`-1: drop, increment `DROP_COUNT`, go to ETH_HDR.
- **Oversize frame.** Payload byte `DATA_BYTES`-1 arrives without LAST: go to DRAIN.
- **DRAIN state.** `MAC_DATA_READY` = 1. Discard bytes until LAST, then increment `DROP_COUNT` and go to ETH_HDR.
- **HOLD state.**
  - `MAC_DATA_READY` = 0 and `MESSAGE_VALID` = 1.
  - `SENDER_*` outputs are registered and stable.
  - On `MESSAGE_READY`, go to ETH_HDR.
- `SENDER_*` outputs update only on the transition into HOLD. They keep their value after handoff.

## Timing
- **Reset values:** state ETH_HDR, `MAC_DATA_READY` 1, `MESSAGE_VALID` 0, `SENDER_*` 0, `DROP_COUNT` 0, counters 0.
- **Reset mid-frame:** the partial frame is discarded and is not counted. The bytes after reset, up to the next LAST, are parsed as a new frame and are normally dropped.
- **Result latency:** `MESSAGE_VALID` rises on the first edge after the LAST beat is accepted.
- **Handoff:** the handshake completes on a cycle with `MESSAGE_VALID && MESSAGE_READY`. `MAC_DATA_READY` returns to 1 on the next cycle.
- **No result buffering:** a second frame is back-pressured while a result is held.
- **Throughput:** 1 byte per cycle. A `MAC_DATA_VALID` gap stalls the parser with no state change.
- **Ready path:** `MAC_DATA_READY` is a function of state only, with no combinational path from `MAC_DATA_VALID`.
- **`DROP_COUNT`:** increments one cycle after the terminating beat. It holds at 0xFFFF; a further drop does not wrap.

## Test plan
- **Valid frame.**
  - Stimulus: dst MAC 02:00:00:00:00:01 (the local MAC), src MAC 0A:0B:0C:0D:0E:0F, dst IP 10.0.0.2 (local), src IP 10.0.0.1, valid checksum, payload 0x5A, 0x03, then 24×0x00, LAST on byte 59.
  - Required: `MESSAGE_VALID` 1 cycle later, `SENDER_MESSAGE` = 0x35A, `SENDER_IP_ADDRESS` = 0x0A000001 decoded LSB-first, `DROP_COUNT` = 0.
- **Address and checksum filtering.** Three frames, each otherwise valid: wrong dst IP (10.0.0.9); broadcast dst MAC; checksum corrupted by 1.
  - Required: first dropped, second accepted, third dropped; `DROP_COUNT` = 2.
- **Back-pressure and gaps.** Hold `MESSAGE_READY` = 0 for 20 cycles, with a second frame queued at the MAC.
  - Required: `MAC_DATA_READY` = 0 throughout and the outputs stable.
  - After READY: the second frame is received intact, including with random `MAC_DATA_VALID` gaps.
- **Runt, oversize, TUSER.**
  - LAST at byte 40: dropped.
  - 70-byte frame: drained, dropped, and the next valid frame is accepted.
  - `TUSER`=1 on LAST: dropped.
  - Required: `DROP_COUNT` = 3 after the sequence.
- **Reset.**
  - `ARESET` at byte 20: all outputs at reset values, and a clean frame after release is accepted.
  - 65 536 bad frames: `DROP_COUNT` saturates at 0xFFFF.
